// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE/LAP state machine, 1/100 s prescaler,
// BCD 00.00-59.99 counter with lap snapshot, and a 4-digit multiplexed scanner.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] disp_d3,
    output logic [3:0] disp_d2,
    output logic [3:0] disp_d1,
    output logic [3:0] disp_d0,
    output logic [3:0] scan_bcd,
    output logic [3:0] an_n,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t        st_r, st_nxt_s;
    logic [PW-1:0] presc_r, presc_nxt_s;
    logic [SW-1:0] scan_r, scan_nxt_s;
    logic [1:0]    idx_r, idx_nxt_s;
    logic [15:0]   cnt_r, cnt_nxt_s;
    logic [15:0]   snap_r, snap_nxt_s;
    logic [15:0]   disp_nxt_s;
    logic [16:0]   inc_s;
    logic          wrap_nxt_s;

    // Ripple BCD increment of {sec tens, sec units, hund tens, hund units}; MSB flags 59.99 -> 00.00
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [3:0] d0, d1, d2, d3;
        logic       w;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        d3 = v[15:12];
        w  = 1'b0;
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                if (d2 == 4'd9) begin
                    d2 = 4'd0;
                    if (d3 == 4'd5) begin
                        d3 = 4'd0;
                        w  = 1'b1;
                    end else begin
                        d3 = d3 + 4'd1;
                    end
                end else begin
                    d2 = d2 + 4'd1;
                end
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {w, d3, d2, d1, d0};
    endfunction

    function automatic logic [3:0] sel_digit(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] d;
        case (i)
            2'd0:    d = v[3:0];
            2'd1:    d = v[7:4];
            2'd2:    d = v[11:8];
            2'd3:    d = v[15:12];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    // Next state; clear is only meaningful in PAUSE, so priority reduces to this decode
    always_comb begin
        st_nxt_s = st_r;
        case (st_r)
            S_IDLE: begin
                if (start_stop) st_nxt_s = S_RUN;
                else            st_nxt_s = S_IDLE;
            end
            S_RUN: begin
                if (start_stop) st_nxt_s = S_PAUSE;
                else if (lap)   st_nxt_s = S_LAP;
                else            st_nxt_s = S_RUN;
            end
            S_LAP: begin
                if (start_stop) st_nxt_s = S_PAUSE;
                else if (lap)   st_nxt_s = S_RUN;
                else            st_nxt_s = S_LAP;
            end
            S_PAUSE: begin
                if (clear)           st_nxt_s = S_IDLE;
                else if (start_stop) st_nxt_s = S_RUN;
                else                 st_nxt_s = S_PAUSE;
            end
            default: st_nxt_s = S_IDLE;
        endcase
    end

    // Prescaler, live count, snapshot and scan datapath
    always_comb begin
        inc_s       = bcd_inc(cnt_r);
        presc_nxt_s = presc_r;
        cnt_nxt_s   = cnt_r;
        wrap_nxt_s  = 1'b0;
        if (st_nxt_s == S_IDLE) begin
            presc_nxt_s = PW'(0);
            cnt_nxt_s   = 16'h0000;
        end else if (st_r == S_PAUSE || st_r == S_IDLE) begin
            presc_nxt_s = presc_r;
        end else if (presc_r == PRESC_MAX) begin
            presc_nxt_s = PW'(0);
            cnt_nxt_s   = inc_s[15:0];
            wrap_nxt_s  = inc_s[16];
        end else begin
            presc_nxt_s = presc_r + PW'(1);
        end

        // Snapshot takes the pre-increment value
        if (st_r == S_RUN && st_nxt_s == S_LAP) begin
            snap_nxt_s = cnt_r;
        end else begin
            snap_nxt_s = snap_r;
        end

        if (scan_r == SCAN_MAX) begin
            scan_nxt_s = SW'(0);
            idx_nxt_s  = idx_r + 2'd1;
        end else begin
            scan_nxt_s = scan_r + SW'(1);
            idx_nxt_s  = idx_r;
        end

        disp_nxt_s = (st_nxt_s == S_LAP) ? snap_nxt_s : cnt_nxt_s;
    end

    // State and registered outputs, all derived from the same next-values so they stay coherent
    always_ff @(posedge clk) begin
        if (reset) begin
            st_r     <= S_IDLE;
            presc_r  <= PW'(0);
            scan_r   <= SW'(0);
            idx_r    <= 2'd0;
            cnt_r    <= 16'h0000;
            snap_r   <= 16'h0000;
            disp_d3  <= 4'd0;
            disp_d2  <= 4'd0;
            disp_d1  <= 4'd0;
            disp_d0  <= 4'd0;
            scan_bcd <= 4'd0;
            an_n     <= 4'b1110;
            running  <= 1'b0;
            lap_hold <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            st_r     <= st_nxt_s;
            presc_r  <= presc_nxt_s;
            scan_r   <= scan_nxt_s;
            idx_r    <= idx_nxt_s;
            cnt_r    <= cnt_nxt_s;
            snap_r   <= snap_nxt_s;
            disp_d3  <= disp_nxt_s[15:12];
            disp_d2  <= disp_nxt_s[11:8];
            disp_d1  <= disp_nxt_s[7:4];
            disp_d0  <= disp_nxt_s[3:0];
            scan_bcd <= sel_digit(disp_nxt_s, idx_nxt_s);
            an_n     <= ~(4'b0001 << idx_nxt_s);
            running  <= (st_nxt_s == S_RUN) || (st_nxt_s == S_LAP);
            lap_hold <= (st_nxt_s == S_LAP);
            wrap     <= wrap_nxt_s;
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: integer-hundredths reference model checked every
// cycle, directed scenarios with literal expectations, then random pulses.
module tb_stopwatch_ctrl;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

    logic       clk, reset, start_stop, lap, clear;
    logic [3:0] disp_d3, disp_d2, disp_d1, disp_d0, scan_bcd, an_n;
    logic       running, lap_hold, wrap;

    int  checks, failures;
    int  m_mode, m_cnt, m_snap, m_phase, m_scan, m_prev;
    bit  m_wrap, model_ok;

    stopwatch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
        .disp_d3(disp_d3), .disp_d2(disp_d2), .disp_d1(disp_d1), .disp_d0(disp_d0),
        .scan_bcd(scan_bcd), .an_n(an_n), .running(running), .lap_hold(lap_hold), .wrap(wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: count as integer hundredths, mode as a plain number
    initial begin
        model_ok = 1'b0;
        m_mode = M_IDLE; m_cnt = 0; m_snap = 0; m_phase = 0; m_scan = 0; m_wrap = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_mode = M_IDLE; m_cnt = 0; m_snap = 0; m_phase = 0; m_scan = 0;
                m_wrap = 1'b0; model_ok = 1'b1;
            end else begin
                m_prev = m_cnt;
                m_wrap = 1'b0;
                if (m_mode == M_RUN || m_mode == M_LAP) begin
                    m_phase = m_phase + 1;
                    if (m_phase == TD) begin
                        m_phase = 0;
                        m_cnt = (m_cnt + 1) % 6000;
                        m_wrap = (m_cnt == 0);
                    end
                end
                if (clear && m_mode == M_PAUSE) begin
                    m_mode = M_IDLE; m_cnt = 0; m_phase = 0;
                end else if (start_stop) begin
                    m_mode = (m_mode == M_RUN || m_mode == M_LAP) ? M_PAUSE : M_RUN;
                end else if (lap && m_mode == M_RUN) begin
                    m_mode = M_LAP; m_snap = m_prev;
                end else if (lap && m_mode == M_LAP) begin
                    m_mode = M_RUN;
                end
                m_scan = m_scan + 1;
            end
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        int shown, idx;
        int e_d[4];
        logic [3:0] one_hot;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                shown  = (m_mode == M_LAP) ? m_snap : m_cnt;
                e_d[3] = shown / 1000;
                e_d[2] = (shown / 100) % 10;
                e_d[1] = (shown / 10) % 10;
                e_d[0] = shown % 10;
                idx    = (m_scan / SD) % 4;
                one_hot = 4'b0001 << idx;
                chk("disp_d3", disp_d3, e_d[3]);
                chk("disp_d2", disp_d2, e_d[2]);
                chk("disp_d1", disp_d1, e_d[1]);
                chk("disp_d0", disp_d0, e_d[0]);
                chk("scan_bcd", scan_bcd, e_d[idx]);
                chk("an_n", an_n, 4'b1111 ^ one_hot);
                chk("running", running, (m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0);
                chk("lap_hold", lap_hold, (m_mode == M_LAP) ? 1 : 0);
                chk("wrap", wrap, m_wrap ? 1 : 0);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic cl);
        start_stop = ss; lap = lp; clear = cl;
        @(negedge clk);
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state and scan sequence
        chk("rst_an_n", an_n, 4'b1110);
        chk("rst_scan_bcd", scan_bcd, 0);
        chk("rst_running", running, 0);
        wait_cycles(1); chk("scan_step0b", an_n, 4'b1110);
        wait_cycles(1); chk("scan_step1", an_n, 4'b1101);
        wait_cycles(2); chk("scan_step2", an_n, 4'b1011);
        wait_cycles(2); chk("scan_step3", an_n, 4'b0111);
        wait_cycles(2); chk("scan_step0", an_n, 4'b1110);

        // 40 cycles of RUN gives 00.10
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(40);
        chk("run40_running", running, 1);
        chk("run40_d1", disp_d1, 1);
        chk("run40_d0", disp_d0, 0);
        chk("run40_model", m_cnt, 10);

        // Lap freeze at 00.05, release shows live 00.10
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(20);
        pulse(1'b0, 1'b1, 1'b0);
        wait_cycles(20);
        chk("lap_d0", disp_d0, 5);
        chk("lap_d1", disp_d1, 0);
        chk("lap_hold", lap_hold, 1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("unlap_d1", disp_d1, 1);
        chk("unlap_d0", disp_d0, 0);
        chk("unlap_hold", lap_hold, 0);

        // Pause holds count and prescaler phase; clear; start_stop+clear in PAUSE
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(13);
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(100);
        chk("pause_d0", disp_d0, 3);
        chk("pause_running", running, 0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(1);
        chk("resume_d0_a", disp_d0, 3);
        wait_cycles(1);
        chk("resume_d0_b", disp_d0, 4);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("clear_d0", disp_d0, 0);
        chk("clear_running", running, 0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(10);
        pulse(1'b1, 1'b0, 1'b0);
        chk("pause2_d0", disp_d0, 2);
        pulse(1'b1, 1'b0, 1'b1);
        chk("ssclr_running", running, 0);
        chk("ssclr_d0", disp_d0, 0);

        // Run up to 59.99 and through the wrap
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(23996);
        chk("pre_d3", disp_d3, 5);
        chk("pre_d2", disp_d2, 9);
        chk("pre_d1", disp_d1, 9);
        chk("pre_d0", disp_d0, 9);
        wait_cycles(4);
        chk("wrap_d3", disp_d3, 0);
        chk("wrap_d0", disp_d0, 0);
        chk("wrap_hi", wrap, 1);
        wait_cycles(1);
        chk("wrap_lo", wrap, 0);
        wait_cycles(3);
        chk("post_wrap_d0", disp_d0, 1);

        // Reset in LAP at 00.37 beats all pulses
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(148);
        pulse(1'b0, 1'b1, 1'b0);
        wait_cycles(5);
        chk("lap37_d1", disp_d1, 3);
        chk("lap37_d0", disp_d0, 7);
        reset = 1'b1; start_stop = 1'b1; lap = 1'b1; clear = 1'b1;
        @(negedge clk);
        chk("rlap_d1", disp_d1, 0);
        chk("rlap_d0", disp_d0, 0);
        chk("rlap_an_n", an_n, 4'b1110);
        chk("rlap_scan", scan_bcd, 0);
        chk("rlap_running", running, 0);
        chk("rlap_lap_hold", lap_hold, 0);
        chk("rlap_wrap", wrap, 0);
        reset = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;

        // Random pulses, occasional reset
        for (int i = 0; i < 4000; i++) begin
            start_stop = ($urandom_range(0, 19) == 0);
            lap        = ($urandom_range(0, 14) == 0);
            clear      = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        reset = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        wait_cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
